// File: rtl/uart_frame_builder.sv
// Response frame serializer: SOF, STATUS, CMD, optional little-endian ADDR, DATA, CRC-8 trailer.
// Optional diagnostic counters are built only when FRAME_BUILDER_DIAG_EN is defined.
module uart_frame_builder #(
    parameter int          MAX_DATA_BYTES = 64,
    parameter logic [7:0]  SOF_BYTE       = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        build_valid,
    output logic        build_ready,
    input  logic [7:0]  build_status,
    input  logic [7:0]  build_cmd,
    input  logic        build_addr_en,
    input  logic [31:0] build_addr,
    input  logic [6:0]  build_len,
    output logic [5:0]  data_rd_idx,
    input  logic [7:0]  data_rd_byte,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        error_len,
    output logic [15:0] diag_frame_cnt,
    output logic [15:0] diag_stall_cnt
);

    localparam logic [6:0] MAX_LEN = 7'(MAX_DATA_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_STATUS, S_CMD, S_ADDR, S_DATA, S_CRC
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        addr_en_q, addr_en_d;
    logic [31:0] addr_q, addr_d;
    logic [6:0]  len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  crc_q, crc_d;
    logic        frame_done_q, frame_done_d;
    logic        error_len_q, error_len_d;
    logic        fire;

    // CRC-8, polynomial 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign tx_valid    = (state_q != S_IDLE);
    assign build_ready = (state_q == S_IDLE);
    assign busy        = !build_ready;
    assign fire        = tx_valid && tx_ready;
    assign data_rd_idx = idx_q;
    assign frame_done  = frame_done_q;
    assign error_len   = error_len_q;

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            S_SOF:    tx_data = SOF_BYTE;
            S_STATUS: tx_data = status_q;
            S_CMD:    tx_data = cmd_q;
            S_ADDR:   tx_data = addr_q[{byte_cnt_q, 3'b000} +: 8];
            S_DATA:   tx_data = data_rd_byte;
            S_CRC:    tx_data = crc_q;
            default:  tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        cmd_d        = cmd_q;
        addr_en_d    = addr_en_q;
        addr_d       = addr_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        idx_d        = idx_q;
        crc_d        = crc_q;
        frame_done_d = 1'b0;
        error_len_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (build_valid) begin
                    if (build_len > MAX_LEN) begin
                        error_len_d = 1'b1;
                    end else begin
                        status_d   = build_status;
                        cmd_d      = build_cmd;
                        addr_en_d  = build_addr_en;
                        addr_d     = build_addr;
                        len_d      = build_len;
                        byte_cnt_d = 2'd0;
                        idx_d      = 6'd0;
                        crc_d      = 8'h00;
                        state_d    = S_SOF;
                    end
                end
            end
            S_SOF: begin
                if (fire) state_d = S_STATUS;
            end
            S_STATUS: begin
                if (fire) begin
                    crc_d   = crc8_next(crc_q, tx_data);
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (fire) begin
                    crc_d = crc8_next(crc_q, tx_data);
                    if (addr_en_q)          state_d = S_ADDR;
                    else if (len_q != 7'd0) state_d = S_DATA;
                    else                    state_d = S_CRC;
                end
            end
            S_ADDR: begin
                if (fire) begin
                    crc_d      = crc8_next(crc_q, tx_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = (len_q != 7'd0) ? S_DATA : S_CRC;
                end
            end
            S_DATA: begin
                if (fire) begin
                    crc_d = crc8_next(crc_q, tx_data);
                    // Index returns to 0 on the last byte so it reads 0 outside DATA.
                    if ({1'b0, idx_q} == len_q - 7'd1) begin
                        idx_d   = 6'd0;
                        state_d = S_CRC;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_CRC: begin
                if (fire) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            status_q     <= 8'h00;
            cmd_q        <= 8'h00;
            addr_en_q    <= 1'b0;
            addr_q       <= 32'h0;
            len_q        <= 7'd0;
            byte_cnt_q   <= 2'd0;
            idx_q        <= 6'd0;
            crc_q        <= 8'h00;
            frame_done_q <= 1'b0;
            error_len_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            cmd_q        <= cmd_d;
            addr_en_q    <= addr_en_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            idx_q        <= idx_d;
            crc_q        <= crc_d;
            frame_done_q <= frame_done_d;
            error_len_q  <= error_len_d;
        end
    end

`ifdef FRAME_BUILDER_DIAG_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (frame_done_d && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        if (tx_valid && !tx_ready && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign diag_frame_cnt = frame_cnt_q;
    assign diag_stall_cnt = stall_cnt_q;
`else
    assign diag_frame_cnt = 16'h0000;
    assign diag_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_frame_builder.sv
// Directed bench for uart_frame_builder: frame contents, latency, backpressure, reset and length errors.
module tb_uart_frame_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        build_valid = 1'b0;
  logic        build_ready;
  logic [7:0]  build_status = 8'h00;
  logic [7:0]  build_cmd = 8'h00;
  logic        build_addr_en = 1'b0;
  logic [31:0] build_addr = 32'h0;
  logic [6:0]  build_len = 7'd0;
  logic [5:0]  data_rd_idx;
  logic [7:0]  data_rd_byte;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        error_len;
  logic [15:0] diag_frame_cnt;
  logic [15:0] diag_stall_cnt;

  logic [7:0]  payload [0:63];
  logic [7:0]  got_q[$];
  logic [5:0]  idx_log[$];
  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          stalls;
  int          unstable;
  int          frame_cycles;
  bit          timed_out;

  uart_frame_builder dut (
    .clk(clk), .rst(rst),
    .build_valid(build_valid), .build_ready(build_ready),
    .build_status(build_status), .build_cmd(build_cmd),
    .build_addr_en(build_addr_en), .build_addr(build_addr), .build_len(build_len),
    .data_rd_idx(data_rd_idx), .data_rd_byte(data_rd_byte),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .error_len(error_len),
    .diag_frame_cnt(diag_frame_cnt), .diag_stall_cnt(diag_stall_cnt)
  );

  assign data_rd_byte = payload[data_rd_idx];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bit-serial reference CRC-8 (poly 0x07)
  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] crc_of_exp();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) c = crc_model(c, exp_q[i]);
    return c;
  endfunction

  // driver tasks
  task automatic send_desc(input logic [7:0] st, input logic [7:0] cmd, input logic aen,
                           input logic [31:0] addr, input logic [6:0] len);
    build_status  = st;
    build_cmd     = cmd;
    build_addr_en = aen;
    build_addr    = addr;
    build_len     = len;
    build_valid   = 1'b1;
  endtask

  task automatic run_frame(input int nbytes, input bit toggle);
    bit rdy;
    bit was_stall;
    logic [7:0] held_data;
    logic [5:0] held_idx;
    int cyc;
    got_q.delete();
    idx_log.delete();
    stalls = 0;
    unstable = 0;
    rdy = 1'b1;
    was_stall = 1'b0;
    held_data = 8'h00;
    held_idx = 6'd0;
    cyc = 0;
    while (got_q.size() < nbytes && cyc < 1000) begin
      tx_ready = toggle ? rdy : 1'b1;
      #1;
      if (was_stall && (tx_data !== held_data || data_rd_idx !== held_idx || tx_valid !== 1'b1))
        unstable++;
      if (tx_valid === 1'b1 && tx_ready) begin
        got_q.push_back(tx_data);
        idx_log.push_back(data_rd_idx);
        was_stall = 1'b0;
      end else if (tx_valid === 1'b1) begin
        stalls++;
        was_stall = 1'b1;
        held_data = tx_data;
        held_idx = data_rd_idx;
      end
      step();
      rdy = ~rdy;
      cyc++;
    end
    tx_ready = 1'b1;
    frame_cycles = cyc;
    timed_out = (got_q.size() < nbytes);
  endtask

  task automatic test_reset();
    step();
    n_cmp++; if (build_ready !== 1'b1) begin n_fail++; $display("FAIL reset_build_ready got=%b want=1", build_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    n_cmp++; if (data_rd_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx got=%0d want=0", data_rd_idx); end
    n_cmp++; if (frame_done !== 1'b0 || error_len !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b want=00", frame_done, error_len); end
    n_cmp++; if (diag_frame_cnt !== 16'h0 || diag_stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_diag got=%h/%h want=0000/0000", diag_frame_cnt, diag_stall_cnt); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_ack();
    send_desc(8'h00, 8'h20, 1'b0, 32'h0, 7'd0);
    step();
    build_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00); exp_q.push_back(8'h20); exp_q.push_back(8'hE0);
    run_frame(4, 1'b0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL wack_timeout got=%0d bytes want=4", got_q.size()); end
    n_cmp++; if (frame_cycles !== 4) begin n_fail++; $display("FAIL wack_cycles got=%0d want=4", frame_cycles); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wack_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (frame_done !== 1'b1 || build_ready !== 1'b1) begin n_fail++; $display("FAIL wack_done got=%b/%b want=1/1", frame_done, build_ready); end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL wack_done_pulse got=%b want=0", frame_done); end
  endtask

  task automatic test_read_resp();
    payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC; payload[3] = 8'hDD;
    send_desc(8'h01, 8'h10, 1'b1, 32'h1000_0004, 7'd4);
    step();
    build_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h01); exp_q.push_back(8'h10);
    exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    exp_q.push_back(crc_of_exp());
    run_frame(12, 1'b1);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rresp_timeout got=%0d bytes want=12", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rresp_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (idx_log[7+i] !== 6'(i)) begin n_fail++; $display("FAIL rresp_idx%0d got=%0d want=%0d", i, idx_log[7+i], i); end
    end
    n_cmp++; if (idx_log[6] !== 6'd0) begin n_fail++; $display("FAIL rresp_idx_addr got=%0d want=0", idx_log[6]); end
    n_cmp++; if (stalls !== 11) begin n_fail++; $display("FAIL rresp_stalls got=%0d want=11", stalls); end
    n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL rresp_stable got=%0d unstable cycles want=0", unstable); end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL rresp_done got=%b want=1", frame_done); end
`ifdef FRAME_BUILDER_DIAG_EN
    n_cmp++; if (diag_stall_cnt !== 16'd11) begin n_fail++; $display("FAIL rresp_diag_stall got=%0d want=11", diag_stall_cnt); end
    n_cmp++; if (diag_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL rresp_diag_frame got=%0d want=2", diag_frame_cnt); end
`else
    n_cmp++; if (diag_stall_cnt !== 16'd0 || diag_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rresp_diag_tied got=%0d/%0d want=0/0", diag_stall_cnt, diag_frame_cnt); end
`endif
    step();
  endtask

  task automatic test_oversize();
    send_desc(8'h03, 8'h20, 1'b0, 32'h0, 7'd65);
    step();
    build_valid = 1'b0;
    n_cmp++; if (error_len !== 1'b1) begin n_fail++; $display("FAIL ovr_error_len got=%b want=1", error_len); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_tx_valid got=%b want=0", tx_valid); end
    n_cmp++; if (build_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_build_ready got=%b want=1", build_ready); end
    step();
    n_cmp++; if (error_len !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_after got=%b/%b want=0/0", error_len, tx_valid); end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 5; i++) payload[i] = 8'(8'h31 + i);
    send_desc(8'h02, 8'h40, 1'b0, 32'h0, 7'd5);
    step();
    build_valid = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (data_rd_idx !== 6'd2 || tx_data !== 8'h33) begin n_fail++; $display("FAIL rmid_pre got=idx%0d/%h want=idx2/33", data_rd_idx, tx_data); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_valid got=%b want=0", tx_valid); end
    n_cmp++; if (build_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ready got=%b/%b want=1/0", build_ready, busy); end
    n_cmp++; if (data_rd_idx !== 6'd0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_outputs got=idx%0d/%h want=idx0/00", data_rd_idx, tx_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done cycle%0d got=%b want=0", i, frame_done); end
    end
    rst = 1'b0;
    step();
    send_desc(8'h00, 8'h20, 1'b0, 32'h0, 7'd0);
    step();
    build_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00); exp_q.push_back(8'h20); exp_q.push_back(8'hE0);
    run_frame(4, 1'b0);
    n_cmp++; if (timed_out || frame_cycles !== 4) begin n_fail++; $display("FAIL rmid_next_cycles got=%0d want=4", frame_cycles); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_next_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL rmid_next_done got=%b want=1", frame_done); end
    step();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    payload[0] = 8'h11;
    send_desc(8'h00, 8'h30, 1'b0, 32'h0, 7'd1);
    step();
    exp_q.delete();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00); exp_q.push_back(8'h30); exp_q.push_back(8'h11);
    exp_q.push_back(crc_of_exp());
    run_frame(5, 1'b0);
    n_cmp++; if (timed_out || frame_cycles !== 5) begin n_fail++; $display("FAIL b2b_first_cycles got=%0d want=5", frame_cycles); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_first_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (frame_done !== 1'b1 || build_ready !== 1'b1 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b/%b/%b want=1/1/0", frame_done, build_ready, tx_valid); end
    step();
    build_valid = 1'b0;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_second_sof got=%b/%h want=1/5a", tx_valid, tx_data); end
    run_frame(5, 1'b0);
    n_cmp++; if (timed_out || frame_cycles !== 5) begin n_fail++; $display("FAIL b2b_second_cycles got=%0d want=5", frame_cycles); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_second_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%b want=1", frame_done); end
`ifdef FRAME_BUILDER_DIAG_EN
    n_cmp++; if (diag_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_diag_frame got=%0d want=2", diag_frame_cnt); end
`else
    n_cmp++; if (diag_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_diag_tied got=%0d want=0", diag_frame_cnt); end
`endif
    step();
  endtask

  task automatic test_max_payload();
    for (int i = 0; i < 64; i++) payload[i] = 8'(i * 7 + 3);
    send_desc(8'h00, 8'h21, 1'b0, 32'h0, 7'd64);
    step();
    build_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00); exp_q.push_back(8'h21);
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i * 7 + 3));
    exp_q.push_back(crc_of_exp());
    run_frame(68, 1'b0);
    n_cmp++; if (timed_out || frame_cycles !== 68) begin n_fail++; $display("FAIL max_cycles got=%0d want=68", frame_cycles); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL max_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if (idx_log[3+i] !== 6'(i)) begin n_fail++; $display("FAIL max_idx%0d got=%0d want=%0d", i, idx_log[3+i], i); end
    end
    n_cmp++; if (idx_log[67] !== 6'd0 || idx_log[2] !== 6'd0) begin n_fail++; $display("FAIL max_idx_outside got=%0d/%0d want=0/0", idx_log[2], idx_log[67]); end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL max_done got=%b want=1", frame_done); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) payload[i] = 8'h00;
    test_reset();
    test_write_ack();
    test_read_resp();
    test_oversize();
    test_reset_mid_frame();
    test_back_to_back();
    test_max_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_builder.md
# uart_frame_builder

Transmit-side counterpart of the UART frame parser in the UART-to-AXI bridge. Accepts one response descriptor from the bridge (status, command echo, optional address, and up to MAX_DATA_BYTES payload bytes). Serializes it as a byte stream toward the UART TX FIFO: SOF, STATUS, CMD, optional ADDR, DATA, and a CRC-8 trailer. Upstream handshake is valid/ready; downstream handshake is valid/ready with full backpressure support.

## Interface
- MAX_DATA_BYTES, 64: maximum payload bytes per frame (1..64)
- SOF_BYTE, 8'h5A: response start-of-frame byte
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- build_valid  in  1  descriptor valid
- build_ready  out  1  builder idle, can accept a descriptor
- build_status  in  8  status byte
- build_cmd  in  8  command byte echoed to host
- build_addr_en  in  1  include the 4-byte address field
- build_addr  in  32  address, sent little-endian
- build_len  in  7  payload byte count, 0..MAX_DATA_BYTES
- data_rd_idx  out  6  payload byte index requested from the bridge buffer
- data_rd_byte  in  8  payload byte at data_rd_idx, combinational, same cycle
- tx_data  out  8  byte to the TX FIFO
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  TX FIFO accepts the byte
- busy  out  1  frame in progress (equals !build_ready)
- frame_done  out  1  one-cycle pulse after the CRC byte is accepted
- error_len  out  1  one-cycle pulse: descriptor rejected because build_len > MAX_DATA_BYTES
- diag_frame_cnt  out  16  frames completed (see Configuration)
- diag_stall_cnt  out  16  cycles with tx_valid && !tx_ready (see Configuration)

## Operation
- States: IDLE, SOF, STATUS, CMD, ADDR, DATA, CRC.
- IDLE:
  - build_ready=1.
  - On build_valid, latch all build_* inputs.
  - If build_len > MAX_DATA_BYTES: pulse error_len next cycle and stay in IDLE.
  - Otherwise go to SOF.
- Each non-IDLE state drives tx_valid=1 and advances only on tx_valid && tx_ready.
- Byte order: SOF_BYTE, status, cmd, then addr[7:0], [15:8], [23:16], [31:24] if addr_en, then data bytes 0..len-1, then CRC.
- Skip rules:
  - ADDR is skipped when addr_en=0.
  - DATA is skipped when len=0.
- Counters:
  - 2-bit byte counter in ADDR.
  - 6-bit counter in DATA, exposed as data_rd_idx.
  - data_rd_idx holds 0 outside DATA.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over STATUS through the last DATA byte; excludes SOF and the CRC byte.
  - Cleared on descriptor accept.
  - Updated with the byte on each accepted transfer in STATUS, CMD, ADDR and DATA.
- Frame length: 4 + 4·addr_en + len bytes.
- From CRC accept: return to IDLE and pulse frame_done.

## Timing
- Reset values:
  - State IDLE, build_ready=1, busy=0.
  - tx_valid=0, tx_data=8'h00, data_rd_idx=0.
  - frame_done=0, error_len=0, CRC register 0, diag counters 0.
- Descriptor accepted at cycle T gives tx_valid=1 with tx_data=SOF_BYTE at T+1.
- With tx_ready held at 1, an N-byte frame occupies cycles T+1..T+N. frame_done and build_ready are both high at T+N+1.
- A new descriptor may be accepted at T+N+1, giving a 1-cycle gap between frames.
- While tx_valid=1 && tx_ready=0, tx_data and data_rd_idx hold stable. tx_valid never deasserts before acceptance.
- Rejected descriptor: error_len=1 at T+1, build_ready stays 1, tx_valid stays 0.
- Reset asserted mid-frame:
  - All outputs return to reset values asynchronously.
  - The partial frame is abandoned; no frame_done pulse.
- build_valid asserted outside IDLE is ignored; it is not latched.

## Configuration
- FRAME_BUILDER_DIAG_EN defined:
  - diag_frame_cnt increments on each frame_done.
  - diag_stall_cnt increments on each tx_valid && !tx_ready cycle.
  - Both saturate at 16'hFFFF and are cleared only by rst.
- Not defined:
  - diag_frame_cnt and diag_stall_cnt are tied to 16'h0000.
  - No counter logic is instantiated.
  - All other behaviour is identical.

## Test plan
- Write ack: status=8'h00, cmd=8'h20, addr_en=0, len=0, tx_ready=1 -> bytes 5A 00 20 E0 on cycles T+1..T+4; frame_done at T+5.
- Read response: addr_en=1, addr=32'h1000_0004, len=4, data AA BB CC DD, tx_ready toggling 1,0,1,0 -> 5A st cmd 04 00 00 10 AA BB CC DD crc. CRC matches model. tx_data is stable during every stall. With DIAG_EN, diag_stall_cnt equals the number of stall cycles.
- Oversize: build_len=MAX_DATA_BYTES+1 -> error_len pulse at T+1, tx_valid stays 0, build_ready stays 1.
- Reset during DATA byte 2 -> tx_valid=0 immediately, no frame_done. After release, build_ready=1 and the next frame is correct.
- Back-to-back: build_valid held high across two frames (len=1 each) -> second SOF appears 2 cycles after the first CRC accept. With DIAG_EN, diag_frame_cnt=2.
- Max payload: len=64, addr_en=0 -> 68 bytes, data_rd_idx runs 0..63, CRC matches model.
